// File: rtl/cnn_out_capture.sv
// cnn_out_capture: result-capture buffer between the CNN core outputs and the
// scan chain. Provides a per-channel last-value latch, an armed capture memory
// (stop-when-full or circular), a MISR signature and a registered readout port.
module cnn_out_capture #(
  parameter int CH    = 2,
  parameter int DW    = 8,
  parameter int DEPTH = 16,
  parameter logic [CH*DW-1:0] POLY = 16'h1021
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         valid_i,
  input  logic [CH*DW-1:0]             data_i,
  input  logic                         arm,
  input  logic                         stop,
  input  logic                         wrap_mode,
  input  logic [$clog2(DEPTH)-1:0]     rd_addr,
  output logic [CH*DW-1:0]             rd_data,
  output logic [CH*DW-1:0]             latch_o,
  output logic [CH*DW-1:0]             sig_o,
  output logic [$clog2(DEPTH):0]       count_o,
  output logic [$clog2(DEPTH)-1:0]     wr_ptr_o,
  output logic                         busy_o,
  output logic                         done_o,
  output logic                         overflow_o
);

  localparam int W  = CH * DW;
  localparam int AW = $clog2(DEPTH);

  localparam logic [AW:0] COUNT_FULL = (AW + 1)'(DEPTH);
  localparam logic [AW:0] COUNT_LAST = (AW + 1)'(DEPTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_DONE    = 2'd2
  } state_t;

  state_t          state_reg;
  state_t          state_next;
  logic            wrap_reg;
  logic [AW-1:0]   wr_ptr_reg;
  logic [AW:0]     count_reg;
  logic [W-1:0]    sig_reg;
  logic [W-1:0]    sig_next;
  logic            overflow_reg;
  logic [W-1:0]    rd_data_reg;
  logic [DW-1:0]   latch_ch [CH];
  logic [W-1:0]    mem [DEPTH];

  logic            cap_we;
  logic            is_full;
  logic            lost_beat;
  logic            overwrite;

  // A beat is stored only in CAPTURE; the arm cycle itself never stores.
  assign cap_we    = (state_reg == ST_CAPTURE) && valid_i && !arm;
  assign is_full   = (count_reg == COUNT_FULL);
  // Stop mode: a beat arriving after the buffer closed is lost.
  assign lost_beat = (state_reg == ST_DONE) && valid_i && !arm && !wrap_reg;
  // Circular mode: once every address holds a beat, each write replaces one.
  assign overwrite = cap_we && wrap_reg && is_full;

  // MISR step: shift left with polynomial feedback, then fold in the beat.
  always_comb begin
    sig_next = {sig_reg[W-2:0], 1'b0} ^ (sig_reg[W-1] ? POLY : '0) ^ data_i;
  end

  // Next-state logic: arm wins from anywhere, stop or fill closes a capture.
  always_comb begin
    state_next = state_reg;
    if (arm) begin
      state_next = ST_CAPTURE;
    end else if (state_reg == ST_CAPTURE) begin
      if (stop) begin
        state_next = ST_DONE;
      end else if (cap_we && !wrap_reg && (count_reg == COUNT_LAST)) begin
        state_next = ST_DONE;
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Capture mode is frozen at arm so a scan reload cannot change it mid-run.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrap_reg <= 1'b0;
    end else if (arm) begin
      wrap_reg <= wrap_mode;
    end
  end

  // Write pointer, saturating beat count and MISR advance on stored beats.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      count_reg  <= '0;
      sig_reg    <= '0;
    end else if (arm) begin
      wr_ptr_reg <= '0;
      count_reg  <= '0;
      sig_reg    <= '0;
    end else if (cap_we) begin
      wr_ptr_reg <= wr_ptr_reg + 1'b1;
      sig_reg    <= sig_next;
      if (!is_full) begin
        count_reg <= count_reg + 1'b1;
      end
    end
  end

  // Sticky overflow flag, cleared only by a new arm.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_reg <= 1'b0;
    end else if (arm) begin
      overflow_reg <= 1'b0;
    end else if (lost_beat || overwrite) begin
      overflow_reg <= 1'b1;
    end
  end

  // Capture memory write port; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (cap_we) begin
      mem[wr_ptr_reg] <= data_i;
    end
  end

  // Registered readout; a same-cycle write to the address returns old data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_reg <= '0;
    end else begin
      rd_data_reg <= mem[rd_addr];
    end
  end

  // Per-channel last-value latch follows every beat regardless of state.
  genvar gi;
  generate
    for (gi = 0; gi < CH; gi++) begin : g_latch
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          latch_ch[gi] <= '0;
        end else if (valid_i) begin
          latch_ch[gi] <= data_i[gi*DW +: DW];
        end
      end
      assign latch_o[gi*DW +: DW] = latch_ch[gi];
    end
  endgenerate

  assign rd_data    = rd_data_reg;
  assign sig_o      = sig_reg;
  assign count_o    = count_reg;
  assign wr_ptr_o   = wr_ptr_reg;
  assign busy_o     = (state_reg == ST_CAPTURE);
  assign done_o     = (state_reg == ST_DONE);
  assign overflow_o = overflow_reg;

endmodule

// File: tb/tb_cnn_out_capture.sv
// Directed bench for cnn_out_capture with CH=2, DW=8, DEPTH=4, POLY=16'h1021.
module tb_cnn_out_capture;

  localparam int CH    = 2;
  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int W     = CH * DW;
  localparam int AW    = $clog2(DEPTH);

  logic          clk;
  logic          rst_n;
  logic          valid_i;
  logic [W-1:0]  data_i;
  logic          arm;
  logic          stop;
  logic          wrap_mode;
  logic [AW-1:0] rd_addr;
  logic [W-1:0]  rd_data;
  logic [W-1:0]  latch_o;
  logic [W-1:0]  sig_o;
  logic [AW:0]   count_o;
  logic [AW-1:0] wr_ptr_o;
  logic          busy_o;
  logic          done_o;
  logic          overflow_o;

  int n_checks = 0;
  int n_fail   = 0;

  cnn_out_capture #(
    .CH(CH), .DW(DW), .DEPTH(DEPTH), .POLY(16'h1021)
  ) dut (
    .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .data_i(data_i),
    .arm(arm), .stop(stop), .wrap_mode(wrap_mode), .rd_addr(rd_addr),
    .rd_data(rd_data), .latch_o(latch_o), .sig_o(sig_o), .count_o(count_o),
    .wr_ptr_o(wr_ptr_o), .busy_o(busy_o), .done_o(done_o),
    .overflow_o(overflow_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
    $display("check %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [W-1:0] d);
    valid_i = 1'b1;
    data_i  = d;
    tick();
    valid_i = 1'b0;
  endtask

  task automatic do_arm(input logic wm);
    arm       = 1'b1;
    wrap_mode = wm;
    tick();
    arm = 1'b0;
  endtask

  task automatic read_chk(input string tag, input logic [AW-1:0] a, input logic [W-1:0] exp);
    rd_addr = a;
    tick();
    chk(tag, 32'(rd_data), 32'(exp));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rd_data"}, 32'(rd_data), 32'h0);
    chk({tag, "_latch"},   32'(latch_o), 32'h0);
    chk({tag, "_sig"},     32'(sig_o), 32'h0);
    chk({tag, "_count"},   32'(count_o), 32'h0);
    chk({tag, "_wr_ptr"},  32'(wr_ptr_o), 32'h0);
    chk({tag, "_busy"},    32'(busy_o), 32'h0);
    chk({tag, "_done"},    32'(done_o), 32'h0);
    chk({tag, "_ovf"},     32'(overflow_o), 32'h0);
  endtask

  initial begin
    rst_n     = 1'b0;
    valid_i   = 1'b0;
    data_i    = '0;
    arm       = 1'b0;
    stop      = 1'b0;
    wrap_mode = 1'b0;
    rd_addr   = '0;

    // Reset / idle
    tick();
    tick();
    chk_all_zero("reset");
    rst_n = 1'b1;
    tick();
    beat(16'hABCD);
    chk("idle_latch", 32'(latch_o), 32'hABCD);
    chk("idle_count", 32'(count_o), 32'h0);
    chk("idle_sig",   32'(sig_o), 32'h0);
    chk("idle_busy",  32'(busy_o), 32'h0);

    // MISR
    do_arm(1'b0);
    chk("misr_busy", 32'(busy_o), 32'h1);
    beat(16'h1234);
    chk("misr_sig1", 32'(sig_o), 32'h1234);
    beat(16'h0001);
    chk("misr_sig2",   32'(sig_o), 32'h2469);
    chk("misr_count",  32'(count_o), 32'h2);
    chk("misr_wr_ptr", 32'(wr_ptr_o), 32'h2);
    read_chk("misr_rd1", 2'd1, 16'h0001);

    // Stop-on-full
    do_arm(1'b0);
    chk("sof_sig_clr", 32'(sig_o), 32'h0);
    beat(16'h0011);
    beat(16'h0022);
    beat(16'h0033);
    chk("sof_done_3", 32'(done_o), 32'h0);
    beat(16'h0044);
    chk("sof_done_4",  32'(done_o), 32'h1);
    chk("sof_busy_4",  32'(busy_o), 32'h0);
    chk("sof_count_4", 32'(count_o), 32'h4);
    chk("sof_ovf_4",   32'(overflow_o), 32'h0);
    beat(16'h0055);
    chk("sof_ovf_5",   32'(overflow_o), 32'h1);
    chk("sof_count_5", 32'(count_o), 32'h4);
    chk("sof_latch_5", 32'(latch_o), 32'h0055);
    read_chk("sof_rd0", 2'd0, 16'h0011);
    read_chk("sof_rd1", 2'd1, 16'h0022);
    read_chk("sof_rd2", 2'd2, 16'h0033);
    read_chk("sof_rd3", 2'd3, 16'h0044);

    // Circular
    do_arm(1'b1);
    chk("circ_ovf_clr", 32'(overflow_o), 32'h0);
    beat(16'h0001);
    beat(16'h0002);
    beat(16'h0003);
    beat(16'h0004);
    chk("circ_ovf_4",   32'(overflow_o), 32'h0);
    chk("circ_count_4", 32'(count_o), 32'h4);
    beat(16'h0005);
    chk("circ_ovf_5",   32'(overflow_o), 32'h1);
    beat(16'h0006);
    chk("circ_wr_ptr", 32'(wr_ptr_o), 32'h2);
    chk("circ_count",  32'(count_o), 32'h4);
    chk("circ_busy",   32'(busy_o), 32'h1);
    chk("circ_done",   32'(done_o), 32'h0);
    read_chk("circ_rd0", 2'd0, 16'h0005);
    read_chk("circ_rd1", 2'd1, 16'h0006);
    read_chk("circ_rd2", 2'd2, 16'h0003);
    read_chk("circ_rd3", 2'd3, 16'h0004);

    // Simultaneous events: arm with a beat, then stop with a beat
    arm       = 1'b1;
    wrap_mode = 1'b1;
    valid_i   = 1'b1;
    data_i    = 16'h00FF;
    tick();
    arm     = 1'b0;
    valid_i = 1'b0;
    chk("sim_arm_count", 32'(count_o), 32'h0);
    chk("sim_arm_latch", 32'(latch_o), 32'h00FF);
    chk("sim_arm_sig",   32'(sig_o), 32'h0);
    chk("sim_arm_busy",  32'(busy_o), 32'h1);
    stop    = 1'b1;
    valid_i = 1'b1;
    data_i  = 16'h0077;
    tick();
    stop    = 1'b0;
    valid_i = 1'b0;
    chk("sim_stop_count", 32'(count_o), 32'h1);
    chk("sim_stop_done",  32'(done_o), 32'h1);
    chk("sim_stop_busy",  32'(busy_o), 32'h0);
    chk("sim_stop_sig",   32'(sig_o), 32'h0077);
    read_chk("sim_rd0", 2'd0, 16'h0077);
    // A late beat in circular DONE is not an overflow and changes nothing.
    beat(16'h0088);
    chk("sim_done_ovf",   32'(overflow_o), 32'h0);
    chk("sim_done_count", 32'(count_o), 32'h1);
    read_chk("sim_done_rd0", 2'd0, 16'h0077);

    // Reset mid-capture
    do_arm(1'b0);
    beat(16'h0A0A);
    beat(16'h0B0B);
    chk("mid_count_pre", 32'(count_o), 32'h2);
    rst_n = 1'b0;
    #2;
    chk_all_zero("mid_rst");
    #1;
    rst_n = 1'b1;
    beat(16'h0C0C);
    beat(16'h0D0D);
    chk("mid_post_count", 32'(count_o), 32'h0);
    chk("mid_post_busy",  32'(busy_o), 32'h0);
    chk("mid_post_latch", 32'(latch_o), 32'h0D0D);
    do_arm(1'b0);
    beat(16'h0E0E);
    chk("mid_rearm_count", 32'(count_o), 32'h1);
    chk("mid_rearm_sig",   32'(sig_o), 32'h0E0E);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
